// File: rtl/sram_ctrl_if.sv
// Request/response port of the async-SRAM controller.
// The master issues valid/ready requests; responses are single-cycle pulses.
interface sram_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Async-SRAM controller with read/write wait states
// and a read-to-write bus turnaround.
module sram_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MX1 =
    (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int MX =
    (MX1 > TURN_CYC) ? MX1 : TURN_CYC;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] RD_LD =
    CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LD =
    CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] TURN_LD =
    CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    TURN     = 3'd5
  } state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
    logic ready;
  } strb_t;

  localparam strb_t STRB_RST = '{
    ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
    dq_oe: 1'b0, ready: 1'b1
  };

  // Pad strobes are a pure function of the state,
  // registered alongside it.
  function automatic strb_t strb(
    input state_e s
  );
    strb_t r;
    r = '{
      ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
      dq_oe: 1'b0, ready: 1'b0
    };
    case (s)
      IDLE:     r.ready = 1'b1;
      RD: begin
        r.ce_n = 1'b0;
        r.oe_n = 1'b0;
      end
      WR_SETUP,
      WR_HOLD: begin
        r.ce_n  = 1'b0;
        r.dq_oe = 1'b1;
      end
      WR_PULSE: begin
        r.ce_n  = 1'b0;
        r.we_n  = 1'b0;
        r.dq_oe = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  state_e            state;
  state_e            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  strb_t             str_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              acc;
  logic              rd_done;
  logic              wr_done;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc     = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          acc = 1'b1;
          if (bus.req_we) begin
            state_n = WR_SETUP;
          end else begin
            state_n = RD;
            cnt_n   = RD_LD;
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          rd_done = 1'b1;
          if (TURN_CYC > 0) begin
            state_n = TURN;
            cnt_n   = TURN_LD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      TURN: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n = cnt - 1'b1;
      end
      WR_SETUP: begin
        state_n = WR_PULSE;
        cnt_n   = WR_LD;
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_n = WR_HOLD;
          wr_done = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WR_HOLD: state_n = IDLE;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      str_q         <= STRB_RST;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      str_q         <= strb(state_n);
      bus.rsp_valid <= rd_done | wr_done;
      if (acc) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (rd_done) begin
        rdata_q    <= sram_dq_i;
        bus.rsp_we <= 1'b0;
      end
      if (wr_done) bus.rsp_we <= 1'b1;
    end
  end

  assign bus.req_ready = str_q.ready;
  assign bus.rsp_rdata = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_dq_o     = wdata_q;
  assign sram_dq_oe    = str_q.dq_oe;
  assign sram_ce_n     = str_q.ce_n;
  assign sram_oe_n     = str_q.oe_n;
  assign sram_we_n     = str_q.we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default build plus a
// RD_WAIT=1/WR_WAIT=4/TURN_CYC=0 build.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
  sram_ctrl_if #(.ADDR_W(16), .DATA_W(16)) b1 ();

  logic [15:0] a0, dqo0, dqi0;
  logic        dqoe0, ce0, oe0, we0;
  logic [15:0] a1, dqo1, dqi1;
  logic        dqoe1, ce1, oe1, we1;

  sram_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .sram_addr(a0), .sram_dq_o(dqo0),
    .sram_dq_i(dqi0), .sram_dq_oe(dqoe0),
    .sram_ce_n(ce0), .sram_oe_n(oe0),
    .sram_we_n(we0)
  );

  sram_ctrl #(
    .RD_WAIT(1), .WR_WAIT(4), .TURN_CYC(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .sram_addr(a1), .sram_dq_o(dqo1),
    .sram_dq_i(dqi1), .sram_dq_oe(dqoe1),
    .sram_ce_n(ce1), .sram_oe_n(oe1),
    .sram_we_n(we1)
  );

  // Behavioural async SRAMs on the pads
  logic [15:0] mem0 [65536];
  logic [15:0] mem1 [65536];
  always @(posedge clk) begin
    if (!ce0 && !we0) mem0[a0] <= dqo0;
    if (!ce1 && !we1) mem1[a1] <= dqo1;
  end
  assign dqi0 = (!ce0 && !oe0) ? mem0[a0] : 16'hDEAD;
  assign dqi1 = (!ce1 && !oe1) ? mem1[a1] : 16'hDEAD;

  typedef struct {
    bit          we;
    logic [15:0] d;
  } exp_t;

  exp_t        q0 [$];
  exp_t        e0;
  logic [15:0] ref0 [logic [15:0]];
  logic [15:0] wlist [$];
  int          acc0;

  task automatic chk(
    input string t,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got=%h want=%h", t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inv(
    input string t,
    input logic ce, oe, we, dqoe, pce,
    input logic [15:0] a, pa, d, pd
  );
    chk({t, "_oe_we_low"}, 32'(!oe && !we), 0);
    chk({t, "_dqoe_rd"}, 32'(dqoe && !oe), 0);
    if (!ce && !pce) begin
      chk({t, "_addr_stable"}, a, pa);
      chk({t, "_data_stable"}, d, pd);
    end
  endtask

  logic        pce0 = 1'b1, pce1 = 1'b1;
  logic [15:0] pa0, pd0, pa1, pd1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      inv("u0", ce0, oe0, we0, dqoe0, pce0,
          a0, pa0, dqo0, pd0);
      inv("u1", ce1, oe1, we1, dqoe1, pce1,
          a1, pa1, dqo1, pd1);
      if (b0.rsp_valid) begin
        if (q0.size() == 0) begin
          chk("rsp0_spurious", 1, 0);
        end else begin
          e0 = q0.pop_front();
          chk("rsp0_we", b0.rsp_we, e0.we);
          if (!e0.we)
            chk("rsp0_rdata", b0.rsp_rdata, e0.d);
        end
      end
    end
    pce0 <= ce0; pa0 <= a0; pd0 <= dqo0;
    pce1 <= ce1; pa1 <= a1; pd1 <= dqo1;
  end

  task automatic issue0(
    input bit we,
    input logic [15:0] a,
    input logic [15:0] d
  );
    b0.req_valid = 1'b1;
    b0.req_we    = we;
    b0.req_addr  = a;
    b0.req_wdata = d;
    for (int k = 0; k < 20 && b0.req_ready !== 1'b1; k++)
      tick();
    chk("ready0_wait", b0.req_ready, 1);
    tick();
    acc0 = cyc;
    if (we) begin
      ref0[a] = d;
      q0.push_back('{1'b1, 16'h0});
    end else begin
      q0.push_back('{1'b0, ref0[a]});
    end
  endtask

  int  pc;
  bit  pwe;
  int  nlow;
  int  rvc;
  logic [15:0] ra, rd;

  initial begin
    rst_n = 1'b0;
    b0.req_valid = 0; b0.req_we = 0;
    b0.req_addr = 0;  b0.req_wdata = 0;
    b1.req_valid = 0; b1.req_we = 0;
    b1.req_addr = 0;  b1.req_wdata = 0;
    tick(); tick();
    chk("rst_ce_n", ce0, 1);
    chk("rst_oe_n", oe0, 1);
    chk("rst_we_n", we0, 1);
    chk("rst_dq_oe", dqoe0, 0);
    chk("rst_rsp_valid", b0.rsp_valid, 0);
    chk("rst_rsp_we", b0.rsp_we, 0);
    chk("rst_rdata", b0.rsp_rdata, 0);
    chk("rst_addr", a0, 0);
    chk("rst_dq_o", dqo0, 0);
    chk("rst_ready", b0.req_ready, 1);
    rst_n = 1'b1;
    tick();

    // abort a write mid-pulse
    issue0(1'b1, 16'h00AA, 16'h5555);
    b0.req_valid = 0;
    tick();
    chk("abort_pulse_we", we0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", we0, 1);
    chk("abort_ce_n", ce0, 1);
    chk("abort_dq_oe", dqoe0, 0);
    q0.delete();
    ref0.delete();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("abort_ready", b0.req_ready, 1);
    chk("abort_no_rsp", b0.rsp_valid, 0);

    // directed write
    issue0(1'b1, 16'h0012, 16'hBEEF);
    b0.req_valid = 0;
    b0.req_addr = 16'h7777;
    b0.req_wdata = 16'h0;
    chk("w1_ce_n", ce0, 0);
    chk("w1_we_n", we0, 1);
    chk("w1_dq_oe", dqoe0, 1);
    chk("w1_addr", a0, 16'h0012);
    chk("w1_data", dqo0, 16'hBEEF);
    chk("w1_ready", b0.req_ready, 0);
    tick();
    chk("w2_we_n", we0, 0);
    tick();
    chk("w3_we_n", we0, 0);
    tick();
    chk("w4_we_n", we0, 1);
    chk("w4_ce_n", ce0, 0);
    chk("w4_rsp_valid", b0.rsp_valid, 1);
    chk("w4_rsp_we", b0.rsp_we, 1);
    tick();
    chk("w5_ready", b0.req_ready, 1);
    chk("w5_rsp_valid", b0.rsp_valid, 0);

    // directed read
    issue0(1'b0, 16'h0012, 16'h0);
    b0.req_valid = 0;
    chk("r1_ce_n", ce0, 0);
    chk("r1_oe_n", oe0, 0);
    chk("r1_dq_oe", dqoe0, 0);
    tick();
    chk("r2_oe_n", oe0, 0);
    tick();
    chk("r3_oe_n", oe0, 1);
    chk("r3_rsp_valid", b0.rsp_valid, 1);
    chk("r3_rsp_we", b0.rsp_we, 0);
    chk("r3_rdata", b0.rsp_rdata, 16'hBEEF);
    chk("r3_ready", b0.req_ready, 0);
    tick();
    chk("r4_ready", b0.req_ready, 1);

    // request held while busy
    issue0(1'b1, 16'h0012, 16'h1111);
    b0.req_valid = 1;
    b0.req_we = 1;
    b0.req_addr = 16'h0034;
    b0.req_wdata = 16'h2222;
    for (int k = 1; k <= 4; k++) begin
      chk("busy_addr", a0, 16'h0012);
      chk("busy_ready", b0.req_ready, 0);
      tick();
    end
    chk("busy_idle_ready", b0.req_ready, 1);
    issue0(1'b1, 16'h0034, 16'h2222);
    b0.req_valid = 0;
    chk("busy_new_addr", a0, 16'h0034);
    for (int k = 0; k < 6; k++) tick();
    chk("rdata_hold", b0.rsp_rdata, 16'hBEEF);
    wlist.push_back(16'h0012);
    wlist.push_back(16'h0034);

    // back-to-back alternating traffic
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        ra = 16'h0040 + 16'($urandom_range(0, 7));
        rd = 16'($urandom);
        wlist.push_back(ra);
      end else begin
        ra = wlist[$urandom_range(0, wlist.size() - 1)];
        rd = 16'($urandom);
      end
      pc = acc0;
      issue0(i % 2 == 0, ra, rd);
      if (i > 0)
        chk("b2b_gap", acc0 - pc, pwe ? 5 : 4);
      pwe = (i % 2 == 0);
    end
    b0.req_valid = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("q0_drained", q0.size(), 0);

    // short-read / long-write build
    b1.req_valid = 1; b1.req_we = 1;
    b1.req_addr = 16'h0056; b1.req_wdata = 16'hA5A5;
    chk("s_w_ready0", b1.req_ready, 1);
    tick();
    b1.req_valid = 0;
    chk("s_w1_we_n", we1, 1);
    chk("s_w1_ce_n", ce1, 0);
    nlow = 0;
    rvc = 0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (!we1) nlow++;
      if (b1.rsp_valid) rvc = k;
    end
    chk("s_w_low_cycles", nlow, 4);
    chk("s_w_rsp_cycle", rvc, 6);
    chk("s_w_rsp_we", b1.rsp_we, 1);
    tick();
    chk("s_w_ready7", b1.req_ready, 1);
    b1.req_valid = 1; b1.req_we = 0;
    tick();
    b1.req_valid = 0;
    chk("s_r1_oe_n", oe1, 0);
    chk("s_r1_ready", b1.req_ready, 0);
    tick();
    chk("s_r2_rsp_valid", b1.rsp_valid, 1);
    chk("s_r2_rsp_we", b1.rsp_we, 0);
    chk("s_r2_rdata", b1.rsp_rdata, 16'hA5A5);
    chk("s_r2_ready", b1.req_ready, 1);
    chk("s_r2_oe_n", oe1, 1);
    tick();

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised asynchronous-SRAM controller. It replaces the fixed single-cycle read/write sequencer with a valid/ready request port, configurable read and write wait states, and a read-to-write bus turnaround. It sits between an on-chip master and an external async SRAM. It owns the chip strobes, the address and data registers, and the data-bus output enable.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 16, SRAM data width
RD_WAIT, 2, cycles oe_n is held low per read (>=1)
WR_WAIT, 2, cycles we_n is held low per write (>=1)
TURN_CYC, 1, idle cycles inserted after a read before returning to IDLE (>=0)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_we  out  1  type of the completed op
rsp_rdata  out  DATA_W  read data, valid while rsp_valid && !rsp_we
sram_addr  out  ADDR_W  SRAM address, from the address register
sram_dq_o  out  DATA_W  write data to the pad
sram_dq_i  in  DATA_W  read data from the pad
sram_dq_oe  out  1  pad output enable
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - ce_n, oe_n and we_n go to 1; dq_oe goes to 0.
  - Address, wdata, rdata and wait counter go to 0.
  - rsp_valid and rsp_we go to 0.
  - Reset mid-operation aborts the access with no rsp_valid.
- SRAM strobes and dq_oe decode from the state register only. There is no combinational path from req_* to any sram_* output.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
- IDLE:
  - req_ready=1; all strobes deasserted; dq_oe=0.
  - On req_valid && req_ready, latch req_addr, req_wdata and req_we.
  - Go to WR_SETUP if req_we=1, else RD. Load the wait counter.
- RD, RD_WAIT cycles:
  - ce_n=0, oe_n=0, dq_oe=0.
  - On the last RD cycle, capture sram_dq_i into rdata.
  - Next state is TURN if TURN_CYC>0, else IDLE.
- TURN, TURN_CYC cycles: all strobes high, dq_oe=0. Then go to IDLE.
- Write sequence:
  - WR_SETUP, 1 cycle: ce_n=0, we_n=1, dq_oe=1; address and data stable.
  - WR_PULSE, WR_WAIT cycles: ce_n=0, we_n=0, dq_oe=1.
  - WR_HOLD, 1 cycle: ce_n=0, we_n=1, dq_oe=1. Then go to IDLE.
- Responses:
  - Write: rsp_valid=1, rsp_we=1 during the WR_HOLD cycle.
  - Read: rsp_valid=1, rsp_we=0 in the cycle after the last RD cycle, with rsp_rdata = the captured value.
  - rsp_rdata holds its value until the next read completes.
- req_ready=0 in every state except IDLE. A request held during a busy period waits; req_* may change freely while req_valid=0.
- Occupancy from the accept edge back to IDLE:
  - Read: RD_WAIT+TURN_CYC cycles.
  - Write: WR_WAIT+2 cycles.
- Wait counter width is $clog2(max(RD_WAIT,WR_WAIT,TURN_CYC)+1). It counts down; the last cycle is at counter==0.
- Invariants:
  - oe_n and we_n are never both 0.
  - dq_oe is never 1 while oe_n=0.
  - sram_addr and sram_dq_o do not change while ce_n=0.
- Unknown state encoding: return to IDLE with all strobes deasserted.

Test Plan:
- Reset with rst_n low mid-WR_PULSE: we_n, ce_n go to 1 and dq_oe to 0 immediately. No rsp_valid. req_ready=1 after release.
- Write accepted at cycle 0, addr 0x0012, data 0xBEEF (defaults):
  - Cycle 1: WR_SETUP, ce_n=0, we_n=1, dq_oe=1, sram_addr=0x0012, sram_dq_o=0xBEEF.
  - Cycles 2-3: we_n=0.
  - Cycle 4: we_n=1, rsp_valid=1, rsp_we=1.
  - Cycle 5: IDLE, req_ready=1.
- Read accepted at cycle 0, addr 0x0012, model returns 0xBEEF:
  - Cycles 1-2: ce_n=0, oe_n=0, dq_oe=0.
  - Cycle 3: TURN, rsp_valid=1, rsp_we=0, rsp_rdata=0xBEEF.
  - Cycle 4: req_ready=1.
- req_valid held high with alternating read/write: exactly one accept per IDLE cycle, with no lost or duplicated requests. The invariant checker (oe_n/we_n/dq_oe) never fires.
- Sweep RD_WAIT=1, WR_WAIT=4, TURN_CYC=0:
  - Read: rsp_valid at cycle 2, req_ready at cycle 2.
  - Write: we_n low for exactly 4 cycles, rsp_valid at cycle 6.
- req_valid asserted while busy with addr 0x0034: sram_addr stays 0x0012 until the current op finishes. 0x0034 is accepted at the first IDLE cycle.
